// File: rtl/prefix_adder_pipe_if.sv
// Operation/result bundle for prefix_adder_pipe: request side (in_*) and result side (out_*).
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on requests, out_valid/out_ready on results.
interface prefix_adder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  // Requester/consumer side: offers operations, accepts results.
  modport master (
    output in_valid, a, b, cin, sub, in_tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, in_tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract with tag, carry-out, signed overflow and zero flags.
// Latency: 3 edges (S1 operand/PG capture, S2 prefix carries, S3 sum/flags), one op per cycle.
// Backpressure: per-stage valid bits; a stalled pipe holds 3 ops; in_ready is combinational from out_ready.
// Optional PPA_SAT_EN: clamp overflowing results to the signed extreme instead of wrapping.
module prefix_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  prefix_adder_pipe_if.slave bus
);
  localparam int LVL = $clog2(WIDTH);

  // Stage valid bits and the "can take new data" chain, built back from the output.
  logic s1_vld, s2_vld, s3_vld;
  logic rdy1, rdy2, rdy3;

  assign rdy3 = !s3_vld || bus.out_ready;
  assign rdy2 = !s2_vld || rdy3;
  assign rdy1 = !s1_vld || rdy2;

  // in_ready is forced low while reset is held, even though every stage is empty then.
  assign bus.in_ready = rst_n && rdy1;

  // S1 state: bitwise propagate/generate against the effective B, and effective carry-in.
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH-1:0] b_eff;

  assign b_eff = bus.sub ? ~bus.b : bus.b;

  // S1: capture an offered operation whenever the stage is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_p   <= '0;
      s1_g   <= '0;
      s1_c0  <= 1'b0;
      s1_tag <= '0;
    end else if (rdy1) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_p   <= bus.a ^ b_eff;
        s1_g   <= bus.a & b_eff;
        // Subtract is a + ~b + 1, so the external carry-in is ignored there.
        s1_c0  <= bus.sub | bus.cin;
        s1_tag <= bus.in_tag;
      end
    end
  end

  // Kogge-Stone tree. The carry-in is folded into bit 0's generate, so the final
  // group generate at bit i is directly the carry out of bit i.
  logic [WIDTH-1:0] pfx_g, pfx_p;

  // Prefix tree: in-place update from the top bit down so each level reads the previous level.
  always_comb begin
    pfx_g    = s1_g;
    pfx_g[0] = s1_g[0] | (s1_p[0] & s1_c0);
    pfx_p    = s1_p;
    for (int l = 0; l < LVL; l++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i >= (1 << l)) begin
          pfx_g[i] = pfx_g[i] | (pfx_p[i] & pfx_g[i - (1 << l)]);
          pfx_p[i] = pfx_p[i] & pfx_p[i - (1 << l)];
        end
      end
    end
  end

  // S2 state: per-bit carry-out from the tree, plus the bitwise propagate for the sum.
  logic [WIDTH-1:0] s2_c, s2_p;
  logic             s2_c0;
  logic [TAG_W-1:0] s2_tag;

  // S2: register the prefix result when S3 can take what S2 currently holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_c   <= '0;
      s2_p   <= '0;
      s2_c0  <= 1'b0;
      s2_tag <= '0;
    end else if (rdy2) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_c   <= pfx_g;
        s2_p   <= s1_p;
        s2_c0  <= s1_c0;
        s2_tag <= s1_tag;
      end
    end
  end

  // Sum and flags from the carries.
  logic [WIDTH-1:0] cin_vec, sum_n;
  logic             cout_n, ovf_n;

  // Result formation: sum = P ^ carry-into-bit, overflow = carry into MSB xor carry out.
  always_comb begin
    cin_vec = {s2_c[WIDTH-2:0], s2_c0};
    cout_n  = s2_c[WIDTH-1];
    ovf_n   = cin_vec[WIDTH-1] ^ cout_n;
    sum_n   = s2_p ^ cin_vec;
`ifdef PPA_SAT_EN
    // On overflow both effective operand signs are equal and that sign is the carry out,
    // so cout picks the extreme: 1 -> most negative, 0 -> most positive.
    if (ovf_n) begin
      sum_n = cout_n ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // S3 state drives the outputs directly, so results hold steady while out_ready is low.
  logic [WIDTH-1:0] s3_sum;
  logic             s3_cout, s3_ovf, s3_zero;
  logic [TAG_W-1:0] s3_tag;

  // S3: load a new result when the presented one is retiring or the stage is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld  <= 1'b0;
      s3_sum  <= '0;
      s3_cout <= 1'b0;
      s3_ovf  <= 1'b0;
      s3_zero <= 1'b0;
      s3_tag  <= '0;
    end else if (rdy3) begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_sum  <= sum_n;
        s3_cout <= cout_n;
        s3_ovf  <= ovf_n;
        s3_zero <= (sum_n == '0);
        s3_tag  <= s2_tag;
      end
    end
  end

  assign bus.out_valid = s3_vld;
  assign bus.sum       = s3_sum;
  assign bus.cout      = s3_cout;
  assign bus.ovf       = s3_ovf;
  assign bus.zero      = s3_zero;
  assign bus.out_tag   = s3_tag;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed and random ops, stall, mid-flight reset.
// Expected results come from an arithmetic reference model pushed into a scoreboard at acceptance.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_prefix_adder_pipe;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prefix_adder_pipe_if #(.WIDTH(16), .TAG_W(4)) bus ();

  prefix_adder_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic rand_bp  = 1'b0;
  logic held_vld = 1'b0;
  exp_t held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; carry into MSB from a 15-bit partial sum.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic [3:0] tag);
    logic [15:0] be;
    logic        c0;
    logic [16:0] full;
    logic [15:0] lo;
    exp_t        e;
    be     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, be} + {16'd0, c0};
    lo     = {1'b0, a[14:0]} + {1'b0, be[14:0]} + {15'd0, c0};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = lo[15] ^ full[16];
`ifdef PPA_SAT_EN
    if (e.ovf) e.sum = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.zero = (e.sum == 16'h0000);
    e.tag  = tag;
    return e;
  endfunction

  task automatic send_exp(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [3:0] tag, input exp_t e);
    logic done;
    done         = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", done, 1);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input logic [3:0] tag);
    send_exp(a, b, cin, sub, tag, model(a, b, cin, sub, tag));
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 200 && q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic reset_outputs(input string phase);
    chk({phase, "_out_valid"}, bus.out_valid, 0);
    chk({phase, "_sum"},       bus.sum, 0);
    chk({phase, "_cout"},      bus.cout, 0);
    chk({phase, "_ovf"},       bus.ovf, 0);
    chk({phase, "_zero"},      bus.zero, 0);
    chk({phase, "_out_tag"},   bus.out_tag, 0);
    chk({phase, "_in_ready"},  bus.in_ready, 0);
  endtask

  task automatic latency_check(input string phase);
    @(negedge clk); chk({phase, "_lat_e1"}, bus.out_valid, 0);
    @(negedge clk); chk({phase, "_lat_e2"}, bus.out_valid, 0);
    @(negedge clk); chk({phase, "_lat_e3"}, bus.out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld && bus.out_valid) begin
        chk("stall_sum",  bus.sum, held.sum);
        chk("stall_flags", {bus.cout, bus.ovf, bus.zero}, {held.cout, held.ovf, held.zero});
        chk("stall_tag",  bus.out_tag, held.tag);
      end
      held_vld = bus.out_valid && !bus.out_ready;
      held     = {bus.sum, bus.cout, bus.ovf, bus.zero, bus.out_tag};
      if (bus.out_valid && bus.out_ready) begin
        chk("unexpected_result", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("tag",  bus.out_tag, e.tag);
          chk("sum",  bus.sum, e.sum);
          chk("cout", bus.cout, e.cout);
          chk("ovf",  bus.ovf, e.ovf);
          chk("zero", bus.zero, e.zero);
        end
      end
    end
  end

  initial begin
    exp_t e31;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h5678;
    bus.cin       = 1'b1;
    bus.sub       = 1'b0;
    bus.in_tag    = 4'hA;
    bus.out_ready = 1'b1;

    // Reset held with an op offered: nothing may get in or out.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs("rst");
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Wrap to zero with carry out; result after the third edge.
    send_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd1, {16'h0000, 1'b1, 1'b0, 1'b1, 4'd1});
    latency_check("wrap");

    // Positive overflow, then subtract with cin ignored.
`ifdef PPA_SAT_EN
    e31 = {16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd2};
`else
    e31 = {16'h8000, 1'b0, 1'b1, 1'b0, 4'd2};
`endif
    send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd2, e31);
    send_exp(16'h0005, 16'h0007, 1'b1, 1'b1, 4'd3, {16'hFFFE, 1'b0, 1'b0, 1'b0, 4'd3});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd4);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 4'd5);
    send(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd6);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 4'd7);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 4'd8);
    drain();

    // Random ops under random backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'(k));
    end
    rand_bp = 1'b0;
    drain();

    // Fill the pipe with out_ready low; a fourth op must wait.
    bus.out_ready = 1'b0;
    send(16'h0010, 16'h0001, 1'b0, 1'b0, 4'd1);
    send(16'h0020, 16'h0002, 1'b0, 1'b0, 4'd2);
    send(16'h0030, 16'h0003, 1'b0, 1'b1, 4'd3);
    bus.a        = 16'h0040;
    bus.b        = 16'h0004;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_tag   = 4'd4;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(16'h0040, 16'h0004, 1'b0, 1'b0, 4'd4);
    send(16'h0050, 16'h0005, 1'b1, 1'b0, 4'd5);
    drain();

    // Two ops in flight when reset hits: both must vanish.
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 4'd7);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 4'd8);
    rst_n = 1'b0;
    q.delete();
    #1;
    reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_exp(16'h0003, 16'h0004, 1'b0, 1'b0, 4'd9, {16'h0007, 1'b0, 1'b0, 1'b0, 4'd9});
    latency_check("after_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
